// File: rtl/nios2_debug_jtag_pkg.sv
// Shared types and constants for the Nios II debug virtual-JTAG host master.
// Optional feature macro: NIOS2_DEBUG_JTAG_MASTER_STATUS_EN.
`default_nettype none

package nios2_debug_jtag_pkg;

  localparam int DR_WIDTH_DEFAULT = 38;
  localparam int IR_WIDTH_DEFAULT = 2;

  localparam logic [1:0] MONITOR   = 2'b00;
  localparam logic [1:0] BREAK     = 2'b01;
  localparam logic [1:0] TRACEMEM  = 2'b10;
  localparam logic [1:0] TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RTI  = 3'd5,
    ST_RESP = 3'd6
  } state_e;

  // tck only toggles while a JTAG sequence is in flight
  function automatic logic tck_active(input state_e s);
    return (s != ST_IDLE) && (s != ST_RESP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nios2_debug_jtag_tck_gen.sv
// tck generator: TCK_HALF clk low then TCK_HALF clk high, with one-cycle
// rise/fall enables marking the clk edge on which tck changes.
`default_nettype none

module nios2_debug_jtag_tck_gen #(
  parameter int TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int CW = (2 * TCK_HALF > 2) ? $clog2(2 * TCK_HALF) : 1;
  localparam logic [CW-1:0] RISE_AT = CW'(TCK_HALF - 1);
  localparam logic [CW-1:0] FALL_AT = CW'(2 * TCK_HALF - 1);

  logic [CW-1:0] cnt;

  assign tck_rise = run && (cnt == RISE_AT);
  assign tck_fall = run && (cnt == FALL_AT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      if (tck_fall) begin
        cnt <= '0;
        tck <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (tck_rise) tck <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nios2_debug_jtag_master.sv
// Host end of the Nios II debug-slave virtual JTAG: UIR/CDR/SDR/UDR/RTI sequencer.
// Optional feature macro: NIOS2_DEBUG_JTAG_MASTER_STATUS_EN (captures ir_out in CDR).
`default_nettype none

module nios2_debug_jtag_master
  import nios2_debug_jtag_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
  parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
  parameter int TCK_HALF = 2,
  parameter int RTI_TCKS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_status,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam int RW = (RTI_TCKS > 1) ? $clog2(RTI_TCKS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);
  localparam logic [RW-1:0] RTI_LAST = RW'(RTI_TCKS - 1);

  state_e              state;
  logic [IR_WIDTH-1:0] cmd_ir_q;
  logic [IR_WIDTH-1:0] ir_cache;
  logic                ir_cache_valid;
  logic [DR_WIDTH-1:0] shift;
  logic [BW-1:0]       bit_cnt;
  logic [RW-1:0]       rti_cnt;
  logic                tck_rise;
  logic                tck_fall;

  nios2_debug_jtag_tck_gen #(
    .TCK_HALF (TCK_HALF)
  ) u_tck_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (tck_active(state)),
    .tck      (vji_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  assign rsp_dr = shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      cmd_ir_q       <= '0;
      ir_cache       <= '0;
      ir_cache_valid <= 1'b0;
      shift          <= '0;
      bit_cnt        <= '0;
      rti_cnt        <= '0;
      vji_tdi        <= 1'b0;
      vji_ir_in      <= '0;
      vji_uir        <= 1'b0;
      vji_cdr        <= 1'b0;
      vji_sdr        <= 1'b0;
      vji_udr        <= 1'b0;
      vji_rti        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ir_q  <= cmd_ir;
            shift     <= cmd_dr;
            cmd_ready <= 1'b0;
            // Skip the IR update when the slave already holds this IR
            if (ir_cache_valid && (cmd_ir == ir_cache)) begin
              state   <= ST_CDR;
              vji_cdr <= 1'b1;
            end else begin
              state     <= ST_UIR;
              vji_uir   <= 1'b1;
              vji_ir_in <= cmd_ir;
            end
          end
        end
        ST_UIR: begin
          if (tck_fall) begin
            vji_uir        <= 1'b0;
            vji_cdr        <= 1'b1;
            ir_cache       <= cmd_ir_q;
            ir_cache_valid <= 1'b1;
            state          <= ST_CDR;
          end
        end
        ST_CDR: begin
          if (tck_fall) begin
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b1;
            vji_tdi <= shift[0];
            bit_cnt <= '0;
            state   <= ST_SDR;
          end
        end
        ST_SDR: begin
          if (tck_rise) shift <= {vji_tdo, shift[DR_WIDTH-1:1]};
          if (tck_fall) begin
            if (bit_cnt == BIT_LAST) begin
              vji_sdr <= 1'b0;
              vji_udr <= 1'b1;
              vji_tdi <= 1'b0;
              state   <= ST_UDR;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              vji_tdi <= shift[0];
            end
          end
        end
        ST_UDR: begin
          if (tck_fall) begin
            vji_udr <= 1'b0;
            vji_rti <= 1'b1;
            rti_cnt <= '0;
            state   <= ST_RTI;
          end
        end
        ST_RTI: begin
          if (tck_fall) begin
            if (rti_cnt == RTI_LAST) begin
              vji_rti   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              rti_cnt <= rti_cnt + RW'(1);
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NIOS2_DEBUG_JTAG_MASTER_STATUS_EN
  logic [IR_WIDTH-1:0] status_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status_q <= '0;
    else if ((state == ST_CDR) && tck_rise) status_q <= vji_ir_out;
  end

  assign rsp_status = status_q;
`else
  logic unused_ir_out;
  assign unused_ir_out = ^vji_ir_out;
  assign rsp_status    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nios2_debug_jtag_master.sv
// Directed, table-driven bench for nios2_debug_jtag_master with a shift-register slave model.
`default_nettype none

module tb_nios2_debug_jtag_master;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_dr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [37:0] rsp_dr;
  logic [1:0]  rsp_status;
  logic        vji_tck;
  logic        vji_tdi;
  logic        vji_tdo;
  logic [1:0]  vji_ir_in;
  logic [1:0]  vji_ir_out;
  logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  nios2_debug_jtag_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_dr     (cmd_dr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dr     (rsp_dr),
    .rsp_status (rsp_status),
    .vji_tck    (vji_tck),
    .vji_tdi    (vji_tdi),
    .vji_tdo    (vji_tdo),
    .vji_ir_in  (vji_ir_in),
    .vji_ir_out (vji_ir_out),
    .vji_uir    (vji_uir),
    .vji_cdr    (vji_cdr),
    .vji_sdr    (vji_sdr),
    .vji_udr    (vji_udr),
    .vji_rti    (vji_rti)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: 38-bit DR that shifts tdi in on tck rise during SDR
  logic [37:0] slave_sr;
  int          tdo_mode;  // 0 loopback, 1 constant one, 2 constant zero
  assign vji_tdo = (tdo_mode == 0) ? slave_sr[0] : (tdo_mode == 1);
  always @(posedge vji_tck) if (vji_sdr) slave_sr <= {vji_tdi, slave_sr[37:1]};

  int tests = 0;
  int fails = 0;
  int strobe_err = 0;
  bit uir_seen;
  bit rsp_seen;

  always @(negedge clk) begin
    if (vji_uir) uir_seen = 1'b1;
    if (rsp_valid) rsp_seen = 1'b1;
    if ($countones({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}) > 1) strobe_err++;
    if ((cmd_ready || rsp_valid) && (|{vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}))
      strobe_err++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command; returns clk cycles from the accept edge to rsp_valid
  task automatic run_cmd(input logic [1:0] ir, input logic [37:0] dr, input int mode,
                         input logic [1:0] irout, output int lat);
    tdo_mode   = mode;
    vji_ir_out = irout;
    uir_seen   = 1'b0;
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    cmd_ir    = ir;
    cmd_dr    = dr;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("rsp_valid_after_hs", {63'd0, rsp_valid}, 64'd0);
    check("cmd_ready_after_hs", {63'd0, cmd_ready}, 64'd1);
  endtask

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] dr;
    int          mode;
    logic [1:0]  ir_out;
    bit          exp_uir;
    int          exp_lat;
    logic [37:0] exp_dr;
  } vec_t;

  vec_t vecs[6];
  int   lat;
  logic [1:0] exp_status;
  int   sdr_rises;
  logic prev_tck;

  initial begin
    vecs[0] = '{2'b01, 38'h15_5555_5555, 0, 2'b11, 1'b1, 180, 38'h15_5555_5555};
    vecs[1] = '{2'b01, 38'h2A_AAAA_AAAA, 0, 2'b01, 1'b0, 176, 38'h15_5555_5555};
    vecs[2] = '{2'b10, 38'h00_1234_5678, 0, 2'b10, 1'b1, 180, 38'h2A_AAAA_AAAA};
    vecs[3] = '{2'b10, 38'h3F_0000_0001, 1, 2'b11, 1'b0, 176, 38'h3F_FFFF_FFFF};
    vecs[4] = '{2'b10, 38'h0A_BCDE_F012, 2, 2'b00, 1'b0, 176, 38'h00_0000_0000};
    vecs[5] = '{2'b11, 38'h01_0203_0405, 0, 2'b11, 1'b1, 180, 38'h0A_BCDE_F012};

    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_ir     = '0;
    cmd_dr     = '0;
    rsp_ready  = 1'b0;
    vji_ir_out = '0;
    tdo_mode   = 0;
    slave_sr   = 38'h15_5555_5555;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("reset_rsp_dr", {26'd0, rsp_dr}, 64'd0);
    check("reset_rsp_status", {62'd0, rsp_status}, 64'd0);
    check("reset_vji", {56'd0, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr,
                        vji_udr, vji_rti}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].ir, vecs[i].dr, vecs[i].mode, vecs[i].ir_out, lat);
`ifdef NIOS2_DEBUG_JTAG_MASTER_STATUS_EN
      exp_status = vecs[i].ir_out;
`else
      exp_status = 2'b00;
`endif
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_uir", i), {63'd0, uir_seen}, {63'd0, vecs[i].exp_uir});
      check($sformatf("v%0d_ir_in", i), {62'd0, vji_ir_in}, {62'd0, vecs[i].ir});
      check($sformatf("v%0d_rsp_dr", i), {26'd0, rsp_dr}, {26'd0, vecs[i].exp_dr});
      check($sformatf("v%0d_status", i), {62'd0, rsp_status}, {62'd0, exp_status});
      if (i == 2) begin
        for (int c = 0; c < 50; c++) begin
          @(posedge clk);
          #1;
          check("hold_resp", {24'd0, rsp_valid, cmd_ready, vji_tck, 1'b0, rsp_dr},
                {24'd0, 1'b1, 1'b0, 1'b0, 1'b0, vecs[i].exp_dr});
        end
      end
      do_rsp();
    end

    // Abort in the middle of SDR, IR 2'b11 is cached from the last vector
    tdo_mode   = 2;
    cmd_ir     = 2'b11;
    cmd_dr     = 38'h2B_3C4D_5E6F;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    sdr_rises = 0;
    prev_tck  = 1'b0;
    for (int c = 0; c < 500 && sdr_rises < 21; c++) begin
      @(negedge clk);
      if (vji_sdr && vji_tck && !prev_tck) sdr_rises++;
      prev_tck = vji_tck;
    end
    check("abort_reached_bit20", 64'(sdr_rises), 64'd21);
    #1 reset_n = 1'b0;
    #1;
    check("abort_vji_zero", {56'd0, vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr,
                             vji_udr, vji_rti}, 64'd0);
    check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("abort_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    rsp_seen = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_rsp", {63'd0, rsp_seen}, 64'd0);

    run_cmd(2'b11, 38'h11_2233_4455, 1, 2'b01, lat);
    check("post_abort_uir", {63'd0, uir_seen}, 64'd1);
    check("post_abort_latency", 64'(lat), 64'd180);
    check("post_abort_ir_in", {62'd0, vji_ir_in}, 64'd3);
    check("post_abort_rsp_dr", {26'd0, rsp_dr}, {26'd0, 38'h3F_FFFF_FFFF});
    do_rsp();

    check("strobe_onehot", 64'(strobe_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nios2_debug_jtag_master.md
Name: nios2_debug_jtag_master

Overview:
- Host end of the Nios II debug-slave virtual-JTAG interface.
- Takes a command {IR value, 38-bit DR word} over a valid/ready port and generates the full sequence on the vji_* signals that the debug slave consumes: tck, tdi, ir_in and the uir/cdr/sdr/udr/rti state strobes.
- Shifts the DR word out while capturing tdo, then returns the 38-bit captured word on a response valid/ready port.
- Used for on-chip debug bridging and for driving the debug slave in simulation in place of sld_virtual_jtag_basic.

Parameters:
- DR_WIDTH, 38, shift-register length (matches the debug slave's sr/jdo).
- IR_WIDTH, 2, virtual IR width.
- TCK_HALF, 2, clk cycles per tck half period (minimum 1).
- RTI_TCKS, 4, tck periods spent in run-test-idle after UDR (minimum 1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_ir  in  IR_WIDTH  IR value to load.
- cmd_dr  in  DR_WIDTH  DR word; LSB is shifted first.
- rsp_valid  out  1  captured word available.
- rsp_ready  in  1  response accepted.
- rsp_dr  out  DR_WIDTH  word captured from tdo.
- rsp_status  out  IR_WIDTH  ir_out sampled in CDR (optional feature).
- vji_tck  out  1  generated tck.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  current IR.
- vji_ir_out  in  IR_WIDTH  slave IR status.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes.

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. ir_cache_valid = 0. FSM in IDLE.
- tck generator:
  - Runs only outside IDLE and RESP.
  - Each tck period is TCK_HALF clk cycles low, then TCK_HALF clk cycles high.
  - Strobes, tdi and ir_in change only on the clk cycle where tck falls.
  - tdo is sampled on the clk cycle where tck rises, i.e. before the slave's posedge update.
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI, RESP.
- IDLE:
  - A cmd_valid && cmd_ready handshake latches cmd_ir and cmd_dr.
  - If ir_cache_valid && cmd_ir == ir_cache, go to CDR; otherwise go to UIR.
- UIR (1 tck): vji_uir = 1, vji_ir_in = cmd_ir. On exit, ir_cache <= cmd_ir and ir_cache_valid <= 1.
- CDR (1 tck): vji_cdr = 1; vji_ir_out is sampled into the status register.
- SDR (DR_WIDTH tcks):
  - vji_sdr = 1; vji_tdi = shift[0].
  - On each tck rise: shift <= {vji_tdo, shift[DR_WIDTH-1:1]}.
  - A bit counter runs 0..DR_WIDTH-1; SDR exits after count DR_WIDTH-1.
- UDR (1 tck): vji_udr = 1.
- RTI (RTI_TCKS tcks): vji_rti = 1, then go to RESP with tck held low.
- RESP:
  - rsp_valid = 1; rsp_dr holds the final shift value and stays stable until the handshake.
  - On rsp_ready, return to IDLE.
  - rsp_ready asserted before rsp_valid has no effect.
- Latency, accept to rsp_valid:
  - With UIR: (3 + DR_WIDTH + RTI_TCKS) * 2 * TCK_HALF clk cycles = 180 at defaults.
  - IR cached (UIR skipped): 176 at defaults.
- vji_ir_in keeps its last value after UIR until the next UIR (it is not cleared in IDLE).
- Exactly one state strobe is high outside IDLE/RESP; none is high in IDLE/RESP.
- Reset mid-operation aborts immediately: tck = 0, all strobes = 0, no response, cache invalidated.
- A cmd_valid that drops without a handshake is ignored. Back-to-back commands are allowed in the cycle after the RESP handshake.

Optional Feature:
- Macro: NIOS2_DEBUG_JTAG_MASTER_STATUS_EN.
- Defined: rsp_status = vji_ir_out sampled on the tck rise in CDR, held with rsp_dr.
- Undefined: rsp_status is tied to 0, the status register is not built, and vji_ir_out is unused.

Decomposition:
- Shared package nios2_debug_jtag_pkg holds:
  - The state enum.
  - DR_WIDTH_DEFAULT = 38, IR_WIDTH_DEFAULT = 2.
  - The debug-slave IR opcode constants: MONITOR = 2'b00, BREAK = 2'b01, TRACEMEM = 2'b10, TRACECTRL = 2'b11.
- One natural sub-module, nios2_debug_jtag_tck_gen. It produces vji_tck plus single-cycle tck_rise/tck_fall enables from a run input and a TCK_HALF counter.

Test Plan:
- After reset, cmd_ir = 2'b01, cmd_dr = 38'h15_5555_5555, slave loopback (tdo = tdi delayed 38 bits):
  - vji_uir pulses, vji_ir_in = 2'b01.
  - rsp_valid exactly 180 clk after accept.
  - rsp_dr = 38'h15_5555_5555.
- Second command with the same cmd_ir = 2'b01: no vji_uir, rsp_valid after 176 clk.
- Next command with cmd_ir = 2'b10: UIR is re-issued and vji_ir_in becomes 2'b10.
- tdo held at 1 through SDR: rsp_dr = 38'h3F_FFFF_FFFF. tdo held at 0: rsp_dr = 0.
- rsp_ready held low for 50 clk in RESP:
  - rsp_valid stays high and rsp_dr stays stable.
  - cmd_ready stays 0 and tck stays low.
- reset_n asserted at SDR bit 20:
  - All vji_* outputs go to 0 asynchronously and no rsp_valid is produced.
  - The next command issues UIR even though its IR matches the aborted one.
- With NIOS2_DEBUG_JTAG_MASTER_STATUS_EN defined and vji_ir_out = 2'b11 during CDR, rsp_status = 2'b11. Without the macro, rsp_status = 2'b00.
